// File: rtl/mux_rr_reg.sv
// N-channel registered multiplexer with valid/ready on every port.
// Arbitration is either a fixed select or a round-robin pointer; one output register, full throughput.
module mux_rr_reg #(
    parameter  int WIDTH = 2,
    parameter  int N     = 4,
    localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SW-1:0]    ptr_q, ptr_d;

    logic             load;
    logic             grant_valid;
    logic [SW-1:0]    grant_idx;
    logic [WIDTH-1:0] grant_data;

    assign load = !out_valid_q || out_ready;

    // Arbitration: never looks at in_data, so in_ready is independent of data values.
    always_comb begin
        int cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (SW'(i) == sel && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SW'(i);
                end
            end
        end else begin
            // Walk the search order backwards so the earliest position (nearest ptr) wins.
            for (int k = N - 1; k >= 0; k--) begin
                cand = int'(ptr_q) + k;
                if (cand >= N) cand = cand - N;
                for (int i = 0; i < N; i++) begin
                    if (i == cand && in_valid[i]) begin
                        grant_valid = 1'b1;
                        grant_idx   = SW'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < N; i++) begin
            if (SW'(i) == grant_idx) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = rst_n && load && grant_valid;
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_data_d = grant_data;
                out_ch_d   = grant_idx;
                if (mode) begin
                    ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
